// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle arithmetic/logic ops, bit-serial shifts
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   s_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;

    logic             accept;
    logic             is_shift;
    logic             shift_start;
    logic             last_step;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] step_val;
    logic             step_out;

    assign accept      = in_valid & in_ready;
    assign is_shift    = op[2] & (op[1] | op[0]);
    assign shift_start = is_shift && (s_amt != '0);
    assign last_step   = (cnt == SHW'(1));

    // Single-cycle result for everything except multi-step shifts; a zero-length shift passes a through
    always_comb begin
        b_eff   = (op == OP_SUB) ? ~b : b;
        sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        alu_res = a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = a;
        endcase
    end

    // One-bit shift of the working register; SRA refills with the current MSB, which is the original MSB
    always_comb begin
        step_val = work;
        step_out = 1'b0;
        case (op_r)
            OP_SHL: begin
                step_val = {work[WIDTH-2:0], 1'b0};
                step_out = work[WIDTH-1];
            end
            OP_SHR: begin
                step_val = {1'b0, work[WIDTH-1:1]};
                step_out = work[0];
            end
            OP_SRA: begin
                step_val = {work[WIDTH-1], work[WIDTH-1:1]};
                step_out = work[0];
            end
            default: begin
                step_val = work;
                step_out = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = shift_start ? EXEC : DONE;
            EXEC:    if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture, serial shifting, and result/flag update only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= '0;
            work     <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r <= op;
                        work <= a;
                        cnt  <= shift_start ? s_amt : '0;
                        if (!shift_start) begin
                            result   <= alu_res;
                            zero     <= (alu_res == '0);
                            negative <= alu_res[WIDTH-1];
                            carry    <= alu_c;
                            overflow <= alu_v;
                        end
                    end
                end
                EXEC: begin
                    work <= step_val;
                    cnt  <= cnt - SHW'(1);
                    if (last_step) begin
                        result   <= step_val;
                        zero     <= (step_val == '0);
                        negative <= step_val[WIDTH-1];
                        carry    <= step_out;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and random scoreboard bench for alu_seq
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [2:0] s_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       negative;
    logic       carry;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       v;
        int         lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .s_amt(s_amt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] res, input logic z, input logic n,
                                input logic c, input logic v, input int lat);
        exp_t e;
        e.res = res; e.z = z; e.n = n; e.c = c; e.v = v; e.lat = lat;
        return e;
    endfunction

    // Reference model using whole-word arithmetic and signed integer range checks
    function automatic exp_t model(input logic [7:0] va, input logic [7:0] vb,
                                   input logic [2:0] vop, input logic [2:0] k);
        exp_t e;
        int   sa;
        int   sbv;
        int   r;
        logic [8:0] s;
        sa  = $signed(va);
        sbv = $signed(vb);
        e.c = 1'b0;
        e.v = 1'b0;
        case (vop)
            3'd0: begin
                s = {1'b0, va} + {1'b0, vb};
                e.res = s[7:0];
                e.c = s[8];
                r = sa + sbv;
                e.v = (r > 127) || (r < -128);
            end
            3'd1: begin
                e.res = va - vb;
                e.c = (va >= vb);
                r = sa - sbv;
                e.v = (r > 127) || (r < -128);
            end
            3'd2: e.res = va & vb;
            3'd3: e.res = va | vb;
            3'd4: e.res = va ^ vb;
            3'd5: begin
                e.res = va << k;
                if (k != 0) e.c = va[8 - int'(k)];
            end
            3'd6: begin
                e.res = va >> k;
                if (k != 0) e.c = va[int'(k) - 1];
            end
            default: begin
                e.res = $signed(va) >>> k;
                if (k != 0) e.c = va[int'(k) - 1];
            end
        endcase
        e.z   = (e.res == 8'h00);
        e.n   = e.res[7];
        e.lat = (vop >= 3'd5 && k != 0) ? int'(k) + 1 : 1;
        return e;
    endfunction

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                        input logic [2:0] k, input exp_t e);
        sb.push_back(e);
        a = va; b = vb; op = vop; s_amt = k;
        in_valid = 1'b1;
        chk("in_ready_at_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); s_amt = 3'($urandom);
    endtask

    task automatic collect(input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk({tag, "_in_ready_busy"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_out_valid"}, out_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_latency"}, lat, e.lat);
            chk({tag, "_result"}, result, e.res);
            chk({tag, "_zero"}, zero, e.z);
            chk({tag, "_negative"}, negative, e.n);
            chk({tag, "_carry"}, carry, e.c);
            chk({tag, "_overflow"}, overflow, e.v);
        end
        if (out_ready) begin
            @(posedge clk); #1;
            chk({tag, "_out_valid_drop"}, out_valid, 0);
            chk({tag, "_in_ready_back"}, in_ready, 1);
        end
    endtask

    initial begin
        logic       seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rop;
        logic [2:0] rk;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; op = 3'd0; s_amt = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, negative, carry, overflow}, 0);
        rst = 1'b0;

        // First cycle after reset release: must be accepted
        send(8'h7F, 8'h01, 3'd0, 3'd0, mk(8'h80, 0, 1, 0, 1, 1));
        collect("add_7f_01");
        send(8'h05, 8'h05, 3'd1, 3'd0, mk(8'h00, 1, 0, 1, 0, 1));
        collect("sub_05_05");
        send(8'hA1, 8'h00, 3'd5, 3'd3, mk(8'h08, 0, 0, 1, 0, 4));
        collect("shl_a1_3");
        send(8'h90, 8'h00, 3'd7, 3'd2, mk(8'hE4, 0, 1, 0, 0, 3));
        collect("sra_90_2");
        send(8'h90, 8'h00, 3'd6, 3'd2, mk(8'h24, 0, 0, 0, 0, 3));
        collect("shr_90_2");

        // Reset in the middle of a long shift discards it
        a = 8'hF0; b = 8'h00; op = 3'd6; s_amt = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort_exec1_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_result", result, 0);
        chk("abort_flags", {zero, negative, carry, overflow}, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", seen, 0);

        // Back-pressure: DONE holds result and ignores new bundles
        out_ready = 1'b0;
        send(8'hFF, 8'h01, 3'd0, 3'd0, mk(8'h00, 1, 0, 1, 0, 1));
        collect("add_ff_01_stall");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 8'h33; b = 8'h44; op = 3'd3; s_amt = 3'd0;
            @(posedge clk); #1;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_result", result, 8'h00);
            chk("stall_flags", {zero, negative, carry, overflow}, 4'b1010);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 0);
        chk("idle_result_retained", result, 8'h00);
        chk("idle_flags_retained", {zero, negative, carry, overflow}, 4'b1010);
        chk("stall_pulses_ignored", sb.size(), 0);

        // Random bundles against the model
        for (int i = 0; i < 16; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom_range(0, 7));
            rk  = 3'($urandom_range(0, 7));
            send(ra, rb, rop, rk, model(ra, rb, rop, rk));
            collect("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values 4..32, powers of two only.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode bundle valid.
REQ-006 in_ready  output  1  block can accept a bundle this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 SRA (arithmetic).
REQ-010 s_amt  input  SHW  shift amount for SHL/SHR/SRA; ignored otherwise.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 result  output  WIDTH  registered result.
REQ-014 zero, negative, carry, overflow  output  1 each  registered flags.

Function
REQ-015 FSM states IDLE, EXEC, DONE; in_ready SHALL be 1 only in IDLE, out_valid SHALL be 1 only in DONE.
REQ-016 Accept = in_valid & in_ready; on accept a, b, op, s_amt SHALL be captured; later input changes SHALL have no effect.
REQ-017 ADD/SUB/AND/OR/XOR, and shifts with s_amt=0: IDLE->DONE on accept; out_valid asserted the cycle after accept (latency 1).
REQ-018 Shifts with s_amt=k>=1: IDLE->EXEC on accept; EXEC shifts the working register exactly one bit per cycle using a down-counter loaded with k; EXEC->DONE on the cycle the k-th shift completes; out_valid asserted k+1 cycles after accept.
REQ-019 DONE->IDLE when out_ready=1; while out_ready=0 result and all flags SHALL hold stable.
REQ-020 No new bundle accepted in EXEC or DONE; in_valid there SHALL be ignored; minimum spacing between accepts is 2 cycles.
REQ-021 ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit sum.
REQ-022 SUB: computed as a + ~b + 1; carry = bit WIDTH of that sum (1 = no borrow).
REQ-023 overflow (ADD/SUB only): 1 when signed operands of the effective addition share MSB and result MSB differs; 0 for all other ops.
REQ-024 AND/OR/XOR: bitwise; carry=0, overflow=0.
REQ-025 SHL fills LSB with 0; SHR fills MSB with 0; SRA replicates original MSB of a.
REQ-026 Shifts: carry = last bit shifted out (bit WIDTH-1 for SHL, bit 0 for SHR/SRA of the operand on the final step); carry=0 when s_amt=0.
REQ-027 Shifts operate on a; b is ignored.
REQ-028 zero = (result==0); negative = result[WIDTH-1]; both for every op.
REQ-029 Outputs SHALL be driven only from registers; no combinational path from any input to any output.
REQ-030 Flags and result update only on the transition into DONE; they retain values through IDLE until the next DONE.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, shift counter 0, result=0, zero=0, negative=0, carry=0, overflow=0, out_valid=0, in_ready=1 the following cycle.
REQ-032 rst SHALL take precedence over accept, shifting and out_ready on the same edge; an operation in EXEC or DONE is discarded without producing output.
REQ-033 in_valid asserted in the first cycle after rst deasserts SHALL be accepted.

Verification (WIDTH=8)
REQ-034 ADD a=0x7F b=0x01, out_ready=1 -> out_valid 1 cycle after accept, result=0x80, negative=1, overflow=1, carry=0, zero=0.
REQ-035 SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=1, overflow=0, negative=0, latency 1.
REQ-036 SHL a=0xA1 s_amt=3 -> out_valid exactly 4 cycles after accept, result=0x08, carry=1, negative=0, in_ready=0 during the 3 EXEC cycles.
REQ-037 SRA a=0x90 s_amt=2 -> out_valid 3 cycles after accept, result=0xE4, negative=1, carry=0; SHR same operands -> result=0x24, negative=0.
REQ-038 ADD 0xFF+0x01 with out_ready=0 for 3 cycles and in_valid pulsed meanwhile -> result=0x00, zero=1, carry=1 held stable, in_ready=0, pulses ignored; release out_ready -> IDLE next cycle, in_ready=1.
REQ-039 SHR a=0xF0 s_amt=7, rst=1 on second EXEC cycle -> next cycle out_valid=0, in_ready=1, result=0x00, all flags 0; no out_valid for the aborted op.
